// File: rtl/multicycle_cpu.sv
// multicycle_cpu: small multicycle load/store CPU with on-chip instruction
// and data memories.
//
// Each instruction walks FETCH -> DECODE -> EXEC [-> MEM] [-> WB] and
// returns to FETCH; HALT and undefined opcodes park the core in HALT until
// reset.
//
// Ports
//   clk          rising-edge clock
//   reset        synchronous active-high reset
//   imem_we      instruction-memory write strobe (also honoured during reset)
//   imem_addr    instruction word index for imem_we
//   imem_wdata   instruction word written on imem_we
//   pc           byte-address program counter
//   instruction  instruction register
//   alu_result   registered ALU output
//   data_out     registered data-memory read word (last LW)
//   retire       one-cycle pulse during the last cycle of an instruction
//   halted       high while in HALT
//   illegal      sticky, set when HALT was entered on an undefined opcode
module multicycle_cpu #(
  parameter int XLEN    = 32,
  parameter int NREGS   = 32,
  parameter int IMEM_AW = 8,
  parameter int DMEM_AW = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               imem_we,
  input  logic [IMEM_AW-1:0] imem_addr,
  input  logic [31:0]        imem_wdata,
  output logic [31:0]        pc,
  output logic [31:0]        instruction,
  output logic [XLEN-1:0]    alu_result,
  output logic [XLEN-1:0]    data_out,
  output logic               retire,
  output logic               halted,
  output logic               illegal
);

  localparam logic [5:0] OP_ADD  = 6'h00;
  localparam logic [5:0] OP_SUB  = 6'h01;
  localparam logic [5:0] OP_AND  = 6'h02;
  localparam logic [5:0] OP_OR   = 6'h03;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_LW   = 6'h10;
  localparam logic [5:0] OP_SW   = 6'h11;
  localparam logic [5:0] OP_BEQ  = 6'h18;
  localparam logic [5:0] OP_HALT = 6'h3F;
  localparam int         RAW     = $clog2(NREGS);

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT
  } state_t;

  logic [31:0]     imem [2**IMEM_AW];
  logic [XLEN-1:0] dmem [2**DMEM_AW];
  logic [XLEN-1:0] regs_q [NREGS];

  state_t          state_q, state_d;
  logic [31:0]     pc_q, pc_d;
  logic [31:0]     ir_q;
  logic [XLEN-1:0] a_q, a_d, b_q, b_d;
  logic [XLEN-1:0] alu_q, alu_d;
  logic [XLEN-1:0] dout_q;
  logic            retire_q, retire_d;
  logic            halted_q, halted_d;
  logic            illegal_q, illegal_d;

  logic [5:0]      op;
  logic [4:0]      rd, rs1, rs2;
  logic [15:0]     imm16;
  logic [XLEN-1:0] imm_x;
  logic [31:0]     br_off;
  logic [XLEN-1:0] rs1_val, rs2_val, wb_data;
  logic            op_legal, rd_ok;
  logic            rf_we, dmem_we;

  // Note that rs2 overlaps imm[15:11]; only R-type, SW and BEQ consume it.
  assign op     = ir_q[31:26];
  assign rd     = ir_q[25:21];
  assign rs1    = ir_q[20:16];
  assign rs2    = ir_q[15:11];
  assign imm16  = ir_q[15:0];
  assign imm_x  = XLEN'($signed(imm16));
  assign br_off = {{14{imm16[15]}}, imm16, 2'b00};

  assign op_legal = op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI,
                               OP_LW, OP_SW, OP_BEQ};

  // R0 and indices beyond the implemented file read as zero.
  assign rs1_val = (rs1 != 5'd0 && 32'(rs1) < 32'(NREGS)) ? regs_q[rs1[RAW-1:0]] : '0;
  assign rs2_val = (rs2 != 5'd0 && 32'(rs2) < 32'(NREGS)) ? regs_q[rs2[RAW-1:0]] : '0;
  assign rd_ok   = (rd != 5'd0) && (32'(rd) < 32'(NREGS));
  assign wb_data = (op == OP_LW) ? dout_q : alu_q;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    a_d       = a_q;
    b_d       = b_q;
    alu_d     = alu_q;
    retire_d  = 1'b0;
    halted_d  = halted_q;
    illegal_d = illegal_q;
    rf_we     = 1'b0;
    dmem_we   = 1'b0;
    case (state_q)
      S_FETCH: begin
        pc_d    = pc_q + 32'd4;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        a_d = rs1_val;
        b_d = rs2_val;
        if (op == OP_HALT) begin
          state_d  = S_HALT;
          halted_d = 1'b1;
        end else if (!op_legal) begin
          state_d   = S_HALT;
          halted_d  = 1'b1;
          illegal_d = 1'b1;
        end else begin
          state_d  = S_EXEC;
          // BEQ completes in EXEC, so its retire pulse starts now.
          retire_d = (op == OP_BEQ);
        end
      end
      S_EXEC: begin
        case (op)
          OP_ADD:  alu_d = a_q + b_q;
          OP_SUB:  alu_d = a_q - b_q;
          OP_AND:  alu_d = a_q & b_q;
          OP_OR:   alu_d = a_q | b_q;
          OP_BEQ:  alu_d = a_q - b_q;
          default: alu_d = a_q + imm_x;
        endcase
        if (op == OP_BEQ) begin
          // pc already points past the BEQ, so the offset is relative to pc+4.
          if (a_q == b_q) pc_d = pc_q + br_off;
          state_d = S_FETCH;
        end else if (op == OP_LW || op == OP_SW) begin
          state_d  = S_MEM;
          retire_d = (op == OP_SW);
        end else begin
          state_d  = S_WB;
          retire_d = 1'b1;
        end
      end
      S_MEM: begin
        if (op == OP_LW) begin
          state_d  = S_WB;
          retire_d = 1'b1;
        end else begin
          dmem_we = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_WB: begin
        rf_we   = 1'b1;
        state_d = S_FETCH;
      end
      default: state_d = S_HALT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      pc_q      <= '0;
      ir_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      alu_q     <= '0;
      dout_q    <= '0;
      retire_q  <= 1'b0;
      halted_q  <= 1'b0;
      illegal_q <= 1'b0;
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      a_q       <= a_d;
      b_q       <= b_d;
      alu_q     <= alu_d;
      retire_q  <= retire_d;
      halted_q  <= halted_d;
      illegal_q <= illegal_d;
      // Memory reads land directly in their output registers.
      if (state_q == S_FETCH) ir_q <= imem[pc_q[IMEM_AW+1:2]];
      if (state_q == S_MEM && op == OP_LW) dout_q <= dmem[alu_q[DMEM_AW+1:2]];
      if (rf_we && rd_ok) regs_q[rd[RAW-1:0]] <= wb_data;
    end
  end

  // Neither memory is touched by reset; a reset cycle suppresses the store.
  always_ff @(posedge clk) begin
    if (imem_we) imem[imem_addr] <= imem_wdata;
  end

  always_ff @(posedge clk) begin
    if (dmem_we && !reset) dmem[alu_q[DMEM_AW+1:2]] <= b_q;
  end

  assign pc          = pc_q;
  assign instruction = ir_q;
  assign alu_result  = alu_q;
  assign data_out    = dout_q;
  assign retire      = retire_q;
  assign halted      = halted_q;
  assign illegal     = illegal_q;

endmodule

// File: tb/tb_multicycle_cpu.sv
module tb_multicycle_cpu;

  localparam logic [31:0] HALT_W = 32'hFC00_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_we = 1'b0;
  logic [7:0]  imem_addr = '0;
  logic [31:0] imem_wdata = '0;
  logic [31:0] pc, instruction, alu_result, data_out;
  logic        retire, halted, illegal;
  logic [31:0] pc16, ir16;
  logic [15:0] alu16, dout16;
  logic        ret16, halt16, ill16;

  multicycle_cpu dut (
    .clk(clk), .reset(reset), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .pc(pc), .instruction(instruction),
    .alu_result(alu_result), .data_out(data_out), .retire(retire),
    .halted(halted), .illegal(illegal)
  );

  multicycle_cpu #(.XLEN(16)) u16 (
    .clk(clk), .reset(reset), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .pc(pc16), .instruction(ir16),
    .alu_result(alu16), .data_out(dout16), .retire(ret16),
    .halted(halt16), .illegal(ill16)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // ISA-level reference state
  logic [31:0] m_imem [256];
  logic [31:0] m_dmem [256];
  logic [31:0] m_r [32];
  logic [31:0] m_pc;
  logic [31:0] m_dout;
  logic [31:0] prog [$];

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rd,
                                        input logic [4:0] rs1, input logic [15:0] imm);
    return {op, rd, rs1, imm};
  endfunction

  function automatic logic [31:0] enc_r(input logic [5:0] op, input logic [4:0] rd,
                                        input logic [4:0] rs1, input logic [4:0] rs2);
    return {op, rd, rs1, rs2, 11'd0};
  endfunction

  function automatic bit is_legal(input logic [5:0] op);
    return op inside {6'h00, 6'h01, 6'h02, 6'h03, 6'h08, 6'h10, 6'h11, 6'h18};
  endfunction

  function automatic logic [31:0] rreg(input logic [4:0] i);
    return (i == 5'd0) ? 32'd0 : m_r[i];
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Holds reset and writes the whole instruction memory (prog, then HALT fill).
  task automatic load_program();
    reset = 1'b1;
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      imem_we    = 1'b1;
      imem_addr  = 8'(i);
      imem_wdata = (i < prog.size()) ? prog[i] : HALT_W;
      m_imem[i]  = imem_wdata;
    end
    @(negedge clk);
    imem_we = 1'b0;
  endtask

  // Executes one instruction on the reference state.
  task automatic m_step(output int cpi, output bit has_alu, output logic [31:0] ea);
    logic [31:0] w, a, b, imm;
    w   = m_imem[m_pc[9:2]];
    a   = rreg(w[20:16]);
    b   = rreg(w[15:11]);
    imm = {{16{w[15]}}, w[15:0]};
    m_pc = m_pc + 32'd4;
    has_alu = 1'b1;
    cpi = 4;
    ea = '0;
    case (w[31:26])
      6'h00: ea = a + b;
      6'h01: ea = a - b;
      6'h02: ea = a & b;
      6'h03: ea = a | b;
      6'h08: ea = a + imm;
      6'h10: begin
        ea = a + imm;
        m_dout = m_dmem[ea[9:2]];
        cpi = 5;
      end
      6'h11: begin
        ea = a + imm;
        m_dmem[ea[9:2]] = b;
      end
      default: begin
        has_alu = 1'b0;
        cpi = 3;
        if (a == b) m_pc = m_pc + (imm << 2);
      end
    endcase
    if (w[31:26] inside {6'h00, 6'h01, 6'h02, 6'h03, 6'h08} && w[25:21] != 5'd0)
      m_r[w[25:21]] = ea;
    if (w[31:26] == 6'h10 && w[25:21] != 5'd0) m_r[w[25:21]] = m_dout;
  endtask

  // Releases reset and checks every retirement against the reference until
  // the core halts or max_ret instructions have retired.
  task automatic run_and_check(input string tag, input int max_ret);
    int c, last, nret, waited, cpi;
    bit has_alu;
    logic [31:0] w, ea;
    bit exp_ill;
    c = 0; last = -1; nret = 0;
    for (int i = 0; i < 32; i++) m_r[i] = '0;
    m_pc = '0;
    m_dout = '0;
    @(negedge clk);
    reset = 1'b0;
    forever begin
      w = m_imem[m_pc[9:2]];
      if (w[31:26] == 6'h3F || !is_legal(w[31:26])) begin
        exp_ill = (w[31:26] != 6'h3F);
        waited = 0;
        while (!halted && waited < 10) begin tick(); c++; waited++; end
        checks++;
        if (!halted || c - last != 3)
          $display("FAIL %s halt_latency: halted=%b cycles=%0d want 3", tag, halted, c - last);
        checks++;
        if (illegal !== exp_ill)
          $display("FAIL %s illegal_flag: got %b want %b", tag, illegal, exp_ill);
        if (illegal !== exp_ill) errors++;
        if (!halted || c - last != 3) errors++;
        m_pc = m_pc + 32'd4;
        checks++;
        if (pc !== m_pc) begin
          errors++;
          $display("FAIL %s halt_pc: got %h want %h", tag, pc, m_pc);
        end
        repeat (3) tick();
        checks++;
        if (!halted || pc !== m_pc || retire !== 1'b0) begin
          errors++;
          $display("FAIL %s halt_absorb: halted=%b pc=%h retire=%b", tag, halted, pc, retire);
        end
        $display("%s HALT pc=%h illegal=%b", tag, pc, illegal);
        return;
      end
      if (nret == max_ret) return;
      waited = 0;
      do begin tick(); c++; waited++; end while (!retire && waited < 12);
      if (!retire) begin
        checks++; errors++;
        $display("FAIL %s retire_timeout: no retire for ir %h within 12 cycles", tag, w);
        return;
      end
      m_step(cpi, has_alu, ea);
      checks++;
      if (c - last != cpi) begin
        errors++;
        $display("FAIL %s cpi: got %0d want %0d (ir %h)", tag, c - last, cpi, w);
      end
      last = c;
      tick(); c++;
      checks++;
      if (retire !== 1'b0) begin
        errors++;
        $display("FAIL %s retire_pulse: still high one cycle later", tag);
      end
      checks++;
      if (pc !== m_pc) begin
        errors++;
        $display("FAIL %s pc: got %h want %h (ir %h)", tag, pc, m_pc, w);
      end
      checks++;
      if (instruction !== w) begin
        errors++;
        $display("FAIL %s ir: got %h want %h", tag, instruction, w);
      end
      if (has_alu) begin
        checks++;
        if (alu_result !== ea) begin
          errors++;
          $display("FAIL %s alu: got %h want %h (ir %h)", tag, alu_result, ea, w);
        end
      end
      checks++;
      if (data_out !== m_dout) begin
        errors++;
        $display("FAIL %s data_out: got %h want %h (ir %h)", tag, data_out, m_dout, w);
      end
      $display("%s RET ir=%h cpi=%0d pc=%h alu=%h dout=%h", tag, w, cpi, pc, alu_result, data_out);
      nret++;
    end
  endtask

  task automatic test_reset(input string tag);
    reset = 1'b1;
    repeat (3) tick();
    checks++;
    if (pc !== 32'd0 || instruction !== 32'd0 || alu_result !== 32'd0 || data_out !== 32'd0 ||
        retire !== 1'b0 || halted !== 1'b0 || illegal !== 1'b0) begin
      errors++;
      $display("FAIL %s reset_state: pc=%h ir=%h alu=%h dout=%h ret=%b halt=%b ill=%b want all 0",
               tag, pc, instruction, alu_result, data_out, retire, halted, illegal);
    end
    $display("%s reset state pc=%h halted=%b illegal=%b", tag, pc, halted, illegal);
  endtask

  // Zero-fills data memory with a store loop so later loads are defined.
  task automatic test_dmem_init();
    int waited = 0;
    prog.delete();
    prog.push_back(enc_i(6'h08, 5'd1, 5'd0, 16'hFC00));
    prog.push_back(enc_i(6'h11, 5'd0, 5'd1, 16'h0400));
    prog.push_back(enc_i(6'h08, 5'd1, 5'd1, 16'd4));
    prog.push_back(enc_i(6'h18, 5'd0, 5'd1, 16'h0001));
    prog.push_back(enc_i(6'h18, 5'd0, 5'd0, 16'hFFFC));
    prog.push_back(HALT_W);
    load_program();
    @(negedge clk);
    reset = 1'b0;
    while (!halted && waited < 6000) begin tick(); waited++; end
    checks++;
    if (!halted || illegal || pc !== 32'd24) begin
      errors++;
      $display("FAIL init_loop: halted=%b illegal=%b pc=%h want 1 0 00000018", halted, illegal, pc);
    end
    for (int i = 0; i < 256; i++) m_dmem[i] = '0;
    $display("init dmem zero-fill done in %0d cycles", waited);
  endtask

  task automatic test_basic();
    prog.delete();
    prog.push_back(enc_i(6'h08, 5'd1, 5'd0, 16'd5));
    prog.push_back(enc_i(6'h08, 5'd2, 5'd0, 16'd7));
    prog.push_back(enc_r(6'h00, 5'd3, 5'd1, 5'd2));
    prog.push_back(HALT_W);
    load_program();
    run_and_check("basic", 100);
    checks++;
    if (alu_result !== 32'd12 || pc !== 32'd16 || !halted || illegal) begin
      errors++;
      $display("FAIL basic_end: alu=%h pc=%h halted=%b illegal=%b want 12 16 1 0",
               alu_result, pc, halted, illegal);
    end
  endtask

  task automatic test_sub();
    prog.delete();
    prog.push_back(enc_i(6'h08, 5'd2, 5'd0, 16'd1));
    prog.push_back(enc_r(6'h01, 5'd1, 5'd0, 5'd2));
    prog.push_back(HALT_W);
    load_program();
    run_and_check("sub", 100);
    checks++;
    if (alu_result !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL sub_wrap32: got %h want ffffffff", alu_result);
    end
    checks++;
    if (alu16 !== 16'hFFFF) begin
      errors++;
      $display("FAIL sub_wrap16: got %h want ffff", alu16);
    end
  endtask

  task automatic test_mem();
    prog.delete();
    prog.push_back(enc_i(6'h08, 5'd1, 5'd0, 16'h00A5));
    prog.push_back(enc_i(6'h08, 5'd7, 5'd0, 16'hF800));
    prog.push_back(enc_i(6'h11, 5'd0, 5'd7, 16'h0808));   // rs2=r1, addr 8
    prog.push_back(enc_i(6'h10, 5'd4, 5'd0, 16'h0008));
    prog.push_back(enc_r(6'h03, 5'd6, 5'd4, 5'd0));
    prog.push_back(HALT_W);
    load_program();
    run_and_check("mem", 100);
    checks++;
    if (data_out !== 32'hA5 || alu_result !== 32'hA5) begin
      errors++;
      $display("FAIL mem_roundtrip: dout=%h r4=%h want a5 a5", data_out, alu_result);
    end
  endtask

  task automatic test_branch();
    int waited = 0;
    logic [31:0] beq_w;
    beq_w = enc_i(6'h18, 5'd0, 5'd0, 16'hFFFF);
    prog.delete();
    prog.push_back(enc_i(6'h08, 5'd1, 5'd0, 16'd3));
    prog.push_back(beq_w);
    load_program();
    run_and_check("beq_taken", 6);
    // Core is in FETCH of pc=4: overwrite that word in the same cycle.
    imem_we = 1'b1; imem_addr = 8'd1; imem_wdata = HALT_W;
    tick();
    imem_we = 1'b0;
    m_imem[1] = HALT_W;
    checks++;
    if (instruction !== beq_w || pc !== 32'd8) begin
      errors++;
      $display("FAIL fetch_collision: ir=%h pc=%h want %h 00000008", instruction, pc, beq_w);
    end
    while (!halted && waited < 20) begin tick(); waited++; end
    checks++;
    if (!halted || illegal || pc !== 32'd8) begin
      errors++;
      $display("FAIL beq_then_halt: halted=%b illegal=%b pc=%h want 1 0 00000008", halted, illegal, pc);
    end
    prog.delete();
    prog.push_back(enc_i(6'h08, 5'd1, 5'd0, 16'd3));
    prog.push_back(enc_i(6'h18, 5'd0, 5'd1, 16'hFFFF));
    prog.push_back(HALT_W);
    load_program();
    run_and_check("beq_not_taken", 100);
    checks++;
    if (pc !== 32'd12) begin
      errors++;
      $display("FAIL beq_fallthrough: halt pc=%h want 0000000c", pc);
    end
  endtask

  task automatic test_illegal();
    prog.delete();
    prog.push_back(enc_i(6'h08, 5'd1, 5'd0, 16'h0011));
    prog.push_back(enc_i(6'h2A, 5'd0, 5'd0, 16'd0));
    load_program();
    run_and_check("illegal", 100);
    checks++;
    if (!halted || !illegal) begin
      errors++;
      $display("FAIL illegal_set: halted=%b illegal=%b want 1 1", halted, illegal);
    end
    test_reset("illegal_reset");
    run_and_check("illegal_rerun", 100);
  endtask

  task automatic abort_at_retire(input string tag, input int n);
    int seen = 0, waited = 0;
    @(negedge clk);
    reset = 1'b0;
    while (seen < n && waited < 100) begin
      tick(); waited++;
      if (retire) seen++;
    end
    checks++;
    if (seen != n) begin
      errors++;
      $display("FAIL %s abort_wait: saw %0d retires want %0d", tag, seen, n);
    end
    reset = 1'b1;
    tick(); tick();
    $display("%s reset asserted in last cycle of instruction %0d", tag, n);
  endtask

  task automatic test_reset_abort();
    prog.delete();
    prog.push_back(enc_i(6'h08, 5'd5, 5'd0, 16'd9));
    prog.push_back(enc_i(6'h08, 5'd1, 5'd0, 16'h005A));
    prog.push_back(enc_i(6'h11, 5'd0, 5'd0, 16'h0810));   // rs2=r1, addr wraps to 16
    load_program();
    abort_at_retire("abort_wb", 1);
    abort_at_retire("abort_sw", 3);
    prog.delete();
    prog.push_back(enc_i(6'h10, 5'd2, 5'd0, 16'h0010));
    prog.push_back(enc_r(6'h03, 5'd3, 5'd5, 5'd0));
    prog.push_back(enc_i(6'h08, 5'd0, 5'd0, 16'd9));
    prog.push_back(enc_r(6'h03, 5'd4, 5'd0, 5'd0));
    prog.push_back(HALT_W);
    load_program();
    run_and_check("after_abort", 100);
    checks++;
    if (data_out !== 32'd0 || alu_result !== 32'd0) begin
      errors++;
      $display("FAIL abort_effects: dout=%h r0=%h want 0 0", data_out, alu_result);
    end
  endtask

  task automatic test_random(input int n);
    int k;
    logic [5:0] op;
    logic [4:0] rd, rs1, rs2;
    logic [15:0] imm;
    for (int p = 0; p < n; p++) begin
      prog.delete();
      for (int i = 0; i < 32; i++) begin
        k   = $urandom_range(0, 40);
        rd  = 5'($urandom_range(0, 7));
        rs1 = 5'($urandom_range(0, 7));
        rs2 = 5'($urandom_range(0, 7));
        imm = {rs2, 11'($urandom)};
        if (k < 12)      prog.push_back(enc_r(6'(k % 4), rd, rs1, rs2));
        else if (k < 20) prog.push_back(enc_i(6'h08, rd, rs1, imm));
        else if (k < 27) prog.push_back(enc_i(6'h10, rd, rs1, imm));
        else if (k < 34) prog.push_back(enc_i(6'h11, rd, rs1, imm));
        else if (k < 40) prog.push_back(enc_i(6'h18, rd, rs1, 16'($urandom_range(0, 6)) - 16'd3));
        else             prog.push_back(enc_i(6'h2A, rd, rs1, imm));
      end
      load_program();
      run_and_check($sformatf("rand%0d", p), 40);
    end
  endtask

  initial begin
    test_reset("power_on");
    test_dmem_init();
    test_reset("after_init");
    test_basic();
    test_sub();
    test_mem();
    test_branch();
    test_illegal();
    test_reset_abort();
    test_random(4);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
